fetch_sched: RTL and testbench

FETCH_SCHED -- requirements
Module: VX_fetch_sched

---
 rtl/fetch_sched.sv | 193 +++++++++++++++++++
 tb/tb_fetch_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sched.sv
// Round-robin warp fetch scheduler with a single registered request slot.
// Optional FETCH_SCHED_PERF_EN adds idle/stall cycle counters.
module fetch_sched #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int PC_BITS     = 30,
    parameter int UUID_WIDTH  = 16,
    parameter int NW_WIDTH    = $clog2(NUM_WARPS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wctl_valid,
    input  logic [NW_WIDTH-1:0]    wctl_wid,
    input  logic                   wctl_start,
    input  logic [PC_BITS-1:0]     wctl_PC,
    input  logic [NUM_THREADS-1:0] wctl_tmask,
    input  logic [NUM_WARPS-1:0]   stall_set,
    input  logic [NUM_WARPS-1:0]   stall_clr,
    input  logic                   br_valid,
    input  logic [NW_WIDTH-1:0]    br_wid,
    input  logic                   br_taken,
    input  logic [PC_BITS-1:0]     br_dest,
    output logic                   sched_valid,
    output logic [NW_WIDTH-1:0]    sched_wid,
    output logic [PC_BITS-1:0]     sched_PC,
    output logic [NUM_THREADS-1:0] sched_tmask,
    output logic [UUID_WIDTH-1:0]  sched_uuid,
    input  logic                   sched_ready,
    input  logic                   rsp_valid,
    input  logic [NW_WIDTH-1:0]    rsp_wid,
    output logic                   busy
`ifdef FETCH_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_idle_cycles,
    output logic [31:0]            perf_stall_cycles
`endif
);

    typedef logic [NW_WIDTH-1:0] wid_t;

    logic [NUM_WARPS-1:0]   active_q, active_d;
    logic [NUM_WARPS-1:0]   stalled_q, stalled_d;
    logic [NUM_WARPS-1:0]   inflight_q, inflight_d;
    logic [PC_BITS-1:0]     pc_q [NUM_WARPS];
    logic [PC_BITS-1:0]     pc_d [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask_d [NUM_WARPS];
    wid_t                   rr_q, rr_d;
    logic [UUID_WIDTH-1:0]  uuid_q, uuid_d;

    logic [NUM_WARPS-1:0]   eligible;
    logic                   sel_found;
    wid_t                   sel_wid;
    wid_t                   sel_idx;
    logic                   slot_open;
    logic                   do_load;

    logic                   valid_d;
    wid_t                   wid_d;
    logic [PC_BITS-1:0]     spc_d;
    logic [NUM_THREADS-1:0] stmask_d;
    logic [UUID_WIDTH-1:0]  suuid_d;

    assign eligible  = active_q & ~stalled_q & ~inflight_q;
    assign busy      = |active_q;
    assign slot_open = ~sched_valid | sched_ready;
    assign do_load   = slot_open & sel_found;

    // First eligible warp at or after rr, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_wid   = '0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            sel_idx = rr_q + wid_t'(i);
            if (!sel_found && eligible[sel_idx]) begin
                sel_found = 1'b1;
                sel_wid   = sel_idx;
            end
        end
    end

    always_comb begin
        valid_d  = sched_valid;
        wid_d    = sched_wid;
        spc_d    = sched_PC;
        stmask_d = sched_tmask;
        suuid_d  = sched_uuid;
        rr_d     = rr_q;
        uuid_d   = uuid_q;
        if (slot_open) begin
            valid_d = sel_found;
            if (sel_found) begin
                wid_d    = sel_wid;
                spc_d    = pc_q[sel_wid];
                stmask_d = tmask_q[sel_wid];
                suuid_d  = uuid_q;
                rr_d     = sel_wid + wid_t'(1);
                uuid_d   = uuid_q + UUID_WIDTH'(1);
            end
        end
    end

    // Later assignments win: wctl > branch > stall_set > stall_clr.
    always_comb begin
        active_d   = active_q;
        stalled_d  = stalled_q;
        inflight_d = inflight_q;
        pc_d       = pc_q;
        tmask_d    = tmask_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (rsp_valid && rsp_wid == wid_t'(w)) begin
                inflight_d[w] = 1'b0;
            end
            if (do_load && sel_wid == wid_t'(w)) begin
                inflight_d[w] = 1'b1;
                pc_d[w]       = pc_q[w] + PC_BITS'(1);
            end
            if (stall_set[w]) begin
                stalled_d[w] = 1'b1;
            end else if (stall_clr[w]) begin
                stalled_d[w] = 1'b0;
            end
            if (br_valid && br_wid == wid_t'(w)) begin
                stalled_d[w] = 1'b0;
                if (br_taken) begin
                    pc_d[w] = br_dest;
                end
            end
            if (wctl_valid && wctl_wid == wid_t'(w)) begin
                if (wctl_start) begin
                    active_d[w]  = 1'b1;
                    stalled_d[w] = 1'b0;
                    pc_d[w]      = wctl_PC;
                    tmask_d[w]   = wctl_tmask;
                end else begin
                    active_d[w] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q    <= '0;
            stalled_q   <= '0;
            inflight_q  <= '0;
            rr_q        <= '0;
            uuid_q      <= '0;
            sched_valid <= 1'b0;
            sched_wid   <= '0;
            sched_PC    <= '0;
            sched_tmask <= '0;
            sched_uuid  <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w]    <= '0;
                tmask_q[w] <= '0;
            end
        end else begin
            active_q    <= active_d;
            stalled_q   <= stalled_d;
            inflight_q  <= inflight_d;
            rr_q        <= rr_d;
            uuid_q      <= uuid_d;
            sched_valid <= valid_d;
            sched_wid   <= wid_d;
            sched_PC    <= spc_d;
            sched_tmask <= stmask_d;
            sched_uuid  <= suuid_d;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w]    <= pc_d[w];
                tmask_q[w] <= tmask_d[w];
            end
        end
    end

`ifdef FETCH_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_idle_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && !sched_valid) begin
                perf_idle_cycles <= perf_idle_cycles + 32'd1;
            end
            if (sched_valid && !sched_ready) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sched.sv
// Self-checking bench for fetch_sched: directed table, corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_fetch_sched;

    localparam int NW  = 4;
    localparam int NT  = 4;
    localparam int PCB = 30;
    localparam int UW  = 16;
    localparam int NWW = 2;

    logic           clk;
    logic           reset;
    logic           wctl_valid;
    logic [NWW-1:0] wctl_wid;
    logic           wctl_start;
    logic [PCB-1:0] wctl_PC;
    logic [NT-1:0]  wctl_tmask;
    logic [NW-1:0]  stall_set;
    logic [NW-1:0]  stall_clr;
    logic           br_valid;
    logic [NWW-1:0] br_wid;
    logic           br_taken;
    logic [PCB-1:0] br_dest;
    logic           sched_valid;
    logic [NWW-1:0] sched_wid;
    logic [PCB-1:0] sched_PC;
    logic [NT-1:0]  sched_tmask;
    logic [UW-1:0]  sched_uuid;
    logic           sched_ready;
    logic           rsp_valid;
    logic [NWW-1:0] rsp_wid;
    logic           busy;
`ifdef FETCH_SCHED_PERF_EN
    logic [31:0]    perf_idle_cycles;
    logic [31:0]    perf_stall_cycles;
`endif

    fetch_sched #(
        .NUM_WARPS  (NW),
        .NUM_THREADS(NT),
        .PC_BITS    (PCB),
        .UUID_WIDTH (UW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wctl_valid (wctl_valid),
        .wctl_wid   (wctl_wid),
        .wctl_start (wctl_start),
        .wctl_PC    (wctl_PC),
        .wctl_tmask (wctl_tmask),
        .stall_set  (stall_set),
        .stall_clr  (stall_clr),
        .br_valid   (br_valid),
        .br_wid     (br_wid),
        .br_taken   (br_taken),
        .br_dest    (br_dest),
        .sched_valid(sched_valid),
        .sched_wid  (sched_wid),
        .sched_PC   (sched_PC),
        .sched_tmask(sched_tmask),
        .sched_uuid (sched_uuid),
        .sched_ready(sched_ready),
        .rsp_valid  (rsp_valid),
        .rsp_wid    (rsp_wid),
        .busy       (busy)
`ifdef FETCH_SCHED_PERF_EN
        ,
        .perf_idle_cycles (perf_idle_cycles),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: per-warp state arrays plus the request slot.
    bit             m_act [NW];
    bit             m_stl [NW];
    bit             m_inf [NW];
    logic [PCB-1:0] m_pc  [NW];
    logic [NT-1:0]  m_tm  [NW];
    int             m_rr;
    logic [UW-1:0]  m_uuid;
    bit             m_sv;
    int             m_swid;
    logic [PCB-1:0] m_spc;
    logic [NT-1:0]  m_stm;
    logic [UW-1:0]  m_suuid;

    task automatic model_step();
        int  sel;
        int  w;
        bit  n_act [NW];
        bit  n_stl [NW];
        bit  n_inf [NW];
        logic [PCB-1:0] n_pc [NW];
        logic [NT-1:0]  n_tm [NW];
        if (!reset) begin
            for (int i = 0; i < NW; i++) begin
                m_act[i] = 0; m_stl[i] = 0; m_inf[i] = 0; m_pc[i] = '0; m_tm[i] = '0;
            end
            m_rr = 0; m_uuid = '0; m_sv = 0;
            return;
        end
        sel = -1;
        for (int k = 0; k < NW; k++) begin
            w = (m_rr + k) % NW;
            if (sel < 0 && m_act[w] && !m_stl[w] && !m_inf[w]) sel = w;
        end
        n_act = m_act; n_stl = m_stl; n_inf = m_inf; n_pc = m_pc; n_tm = m_tm;
        if (rsp_valid) n_inf[rsp_wid] = 0;
        if (!m_sv || sched_ready) begin
            if (sel >= 0) begin
                m_sv = 1; m_swid = sel; m_spc = m_pc[sel]; m_stm = m_tm[sel];
                m_suuid = m_uuid;
                m_uuid = m_uuid + 1'b1;
                n_inf[sel] = 1;
                n_pc[sel] = m_pc[sel] + 1'b1;
                m_rr = (sel + 1) % NW;
            end else begin
                m_sv = 0;
            end
        end
        for (int i = 0; i < NW; i++) begin
            if (stall_set[i]) n_stl[i] = 1;
            else if (stall_clr[i]) n_stl[i] = 0;
        end
        if (br_valid) begin
            n_stl[br_wid] = 0;
            if (br_taken) n_pc[br_wid] = br_dest;
        end
        if (wctl_valid) begin
            if (wctl_start) begin
                n_act[wctl_wid] = 1; n_stl[wctl_wid] = 0;
                n_pc[wctl_wid] = wctl_PC; n_tm[wctl_wid] = wctl_tmask;
            end else begin
                n_act[wctl_wid] = 0;
            end
        end
        m_act = n_act; m_stl = n_stl; m_inf = n_inf; m_pc = n_pc; m_tm = n_tm;
    endtask

    task automatic step();
        bit exp_busy;
        @(posedge clk);
        model_step();
        #1;
        exp_busy = 0;
        for (int i = 0; i < NW; i++) exp_busy |= m_act[i];
        chk("model_valid", sched_valid, m_sv);
        chk("model_busy", busy, exp_busy);
        if (m_sv) begin
            chk("model_wid", sched_wid, m_swid);
            chk("model_pc", sched_PC, m_spc);
            chk("model_tmask", sched_tmask, m_stm);
            chk("model_uuid", sched_uuid, m_suuid);
        end
    endtask

    task automatic idle();
        wctl_valid = 0; wctl_wid = '0; wctl_start = 0; wctl_PC = '0; wctl_tmask = '0;
        stall_set = '0; stall_clr = '0;
        br_valid = 0; br_wid = '0; br_taken = 0; br_dest = '0;
        rsp_valid = 0; rsp_wid = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        step();
        step();
        reset = 1;
    endtask

    task automatic activate(input int w, input logic [PCB-1:0] pc, input logic [NT-1:0] tm);
        wctl_valid = 1; wctl_wid = NWW'(w); wctl_start = 1; wctl_PC = pc; wctl_tmask = tm;
        step();
        idle();
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!sched_valid && n < budget) begin
            step();
            n++;
        end
        chk("wait_valid", sched_valid, 1'b1);
    endtask

    typedef struct {
        logic           wv;
        logic [NWW-1:0] wid;
        logic           st;
        logic [PCB-1:0] pc;
        logic [NT-1:0]  tm;
        logic           rdy;
        logic           rv;
        logic [NWW-1:0] rwid;
        logic           ev;
        logic [NWW-1:0] ewid;
        logic [PCB-1:0] epc;
        logic [UW-1:0]  euuid;
        logic           ebusy;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [31:0]    r;
        logic [NWW-1:0] rec_wid;
        logic [PCB-1:0] rec_pc;
        logic [UW-1:0]  rec_uuid;
        int             fired [$];
        bit             p1_v, p2_v;
        logic [NWW-1:0] p1_w, p2_w;

        tbl[0] = '{1, 2, 1, 30'h100, 4'hf, 1, 0, 0, 0, 0, 30'h0,   16'd0, 1};
        tbl[1] = '{0, 0, 0, 30'h0,   4'h0, 1, 0, 0, 1, 2, 30'h100, 16'd0, 1};
        tbl[2] = '{0, 0, 0, 30'h0,   4'h0, 1, 0, 0, 0, 0, 30'h0,   16'd0, 1};
        tbl[3] = '{0, 0, 0, 30'h0,   4'h0, 1, 1, 2, 0, 0, 30'h0,   16'd0, 1};
        tbl[4] = '{0, 0, 0, 30'h0,   4'h0, 1, 0, 0, 1, 2, 30'h101, 16'd1, 1};
        tbl[5] = '{0, 0, 0, 30'h0,   4'h0, 0, 0, 0, 1, 2, 30'h101, 16'd1, 1};
        tbl[6] = '{0, 0, 0, 30'h0,   4'h0, 1, 0, 0, 0, 0, 30'h0,   16'd0, 1};
        tbl[7] = '{1, 2, 0, 30'h0,   4'h0, 1, 0, 0, 0, 0, 30'h0,   16'd0, 0};

        sched_ready = 1;
        do_reset();
        chk("reset_valid", sched_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_pc", sched_PC, '0);
        chk("reset_uuid", sched_uuid, '0);

        // Single warp issue, inflight blocking and reissue.
        for (int i = 0; i < 8; i++) begin
            idle();
            wctl_valid = tbl[i].wv; wctl_wid = tbl[i].wid; wctl_start = tbl[i].st;
            wctl_PC = tbl[i].pc; wctl_tmask = tbl[i].tm;
            sched_ready = tbl[i].rdy; rsp_valid = tbl[i].rv; rsp_wid = tbl[i].rwid;
            step();
            chk($sformatf("tbl%0d_valid", i), sched_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_wid", i), sched_wid, tbl[i].ewid);
                chk($sformatf("tbl%0d_pc", i), sched_PC, tbl[i].epc);
                chk($sformatf("tbl%0d_uuid", i), sched_uuid, tbl[i].euuid);
            end
        end

        // Four warps, responses two cycles after each fire: strict rotation.
        do_reset();
        sched_ready = 1;
        p1_v = 0; p2_v = 0; p1_w = '0; p2_w = '0;
        for (int i = 0; i < 24; i++) begin
            idle();
            if (i < 4) begin
                wctl_valid = 1; wctl_wid = NWW'(i); wctl_start = 1;
                wctl_PC = PCB'(i * 16); wctl_tmask = 4'hf;
            end
            rsp_valid = p2_v; rsp_wid = p2_w;
            p2_v = p1_v; p2_w = p1_w;
            p1_v = sched_valid; p1_w = sched_wid;
            if (sched_valid) fired.push_back(int'(sched_wid));
            step();
        end
        chk("rr_fire_count", fired.size() >= 16, 1'b1);
        for (int i = 0; i < 12 && i < fired.size(); i++) begin
            chk($sformatf("rr_order%0d", i), fired[i], i % 4);
        end

        // Held request stays stable through a deactivate; no reissue afterwards.
        do_reset();
        sched_ready = 0;
        activate(1, 30'h200, 4'h3);
        wait_valid(5);
        rec_wid = sched_wid; rec_pc = sched_PC; rec_uuid = sched_uuid;
        chk("hold_wid", rec_wid, 1);
        wctl_valid = 1; wctl_wid = 1; wctl_start = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            idle();
            chk("hold_valid", sched_valid, 1'b1);
            chk("hold_payload", {sched_wid, sched_PC, sched_uuid}, {rec_wid, rec_pc, rec_uuid});
        end
        sched_ready = 1;
        step();
        chk("hold_fired", sched_valid, 1'b0);
        rsp_valid = 1; rsp_wid = 1;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_no_reissue", sched_valid, 1'b0);
        end

        // Stall set and taken branch on the same warp and cycle.
        do_reset();
        sched_ready = 0;
        activate(3, 30'h10, 4'h5);
        wait_valid(5);
        chk("br_first_pc", sched_PC, 30'h10);
        stall_set = 4'b1000; br_valid = 1; br_wid = 3; br_taken = 1; br_dest = 30'h40;
        step();
        idle();
        sched_ready = 1;
        step();
        rsp_valid = 1; rsp_wid = 3;
        step();
        idle();
        wait_valid(4);
        chk("br_wid", sched_wid, 3);
        chk("br_pc", sched_PC, 30'h40);

        // Reset while a request is held.
        do_reset();
        sched_ready = 0;
        activate(0, 30'h7, 4'h1);
        wait_valid(5);
        reset = 0;
        step();
        chk("rst_mid_valid", sched_valid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        reset = 1;
        activate(0, 30'h9, 4'h1);
        wait_valid(5);
        chk("rst_mid_uuid", sched_uuid, 16'd0);
        chk("rst_mid_pc", sched_PC, 30'h9);

`ifdef FETCH_SCHED_PERF_EN
        do_reset();
        sched_ready = 0;
        activate(0, 30'h1, 4'h1);
        wait_valid(5);
        for (int i = 0; i < 7; i++) step();
        sched_ready = 1;
        step();
        chk("perf_stall", perf_stall_cycles, 32'd7);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            reset = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 7) == 0) begin
                wctl_valid = 1;
                wctl_wid = NWW'($urandom_range(0, NW - 1));
                wctl_start = ($urandom_range(0, 3) != 0);
                r = $urandom; wctl_PC = r[PCB-1:0];
                r = $urandom; wctl_tmask = r[NT-1:0];
            end
            for (int i = 0; i < NW; i++) begin
                stall_set[i] = ($urandom_range(0, 15) == 0);
                stall_clr[i] = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 7) == 0) begin
                br_valid = 1;
                br_wid = NWW'($urandom_range(0, NW - 1));
                br_taken = $urandom_range(0, 1) == 1;
                r = $urandom; br_dest = r[PCB-1:0];
            end
            rsp_valid = ($urandom_range(0, 1) == 1);
            rsp_wid = NWW'($urandom_range(0, NW - 1));
            sched_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
